// File: rtl/stk_pkg.sv
// Shared stack-pipeline types: opcodes, engine ids and issue credit sizing.
package stk_pkg;

  typedef enum logic [1:0] {
    OPCODE_NOP  = 2'd0,
    OPCODE_PUSH = 2'd1,
    OPCODE_POP  = 2'd2,
    OPCODE_INV  = 2'd3
  } opcode_t;

  localparam int ENGID_W = 2;
  typedef logic [ENGID_W-1:0] engid_t;

  localparam int INFLIGHT_DFLT = 4;

  function automatic int cred_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CRED_W = cred_w(INFLIGHT_DFLT);

endpackage

// File: rtl/stk_rr_arb.sv
// Rotating-priority arbiter; owns the round-robin pointer.
module stk_rr_arb
  import stk_pkg::*;
#(
  parameter int ENGS_N = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [ENGS_N-1:0] req,
  input  logic              upd,
  output logic [ENGS_N-1:0] gnt,
  output engid_t            gnt_idx
);

  localparam engid_t LAST = engid_t'(ENGS_N - 1);

  engid_t rr_ptr_r;

  // Scan from farthest to nearest so the nearest request wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = ENGS_N - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_r) + k;
      if (idx >= ENGS_N) idx = idx - ENGS_N;
      if (req[idx]) gnt_idx = engid_t'(idx);
    end
    if (|req) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rr_ptr_r <= '0;
    end else if (upd) begin
      rr_ptr_r <= (gnt_idx == LAST) ? '0 : gnt_idx + engid_t'(1);
    end
  end

endmodule

// File: rtl/stk_issue_arb.sv
// Issues engine stack commands into LK with per-engine hazard hold-off,
// credit-bounded in-flight count and PUSH stall on pointer exhaustion.
module stk_issue_arb
  import stk_pkg::*;
#(
  parameter int ENGS_N     = 4,
  parameter int INFLIGHT_N = INFLIGHT_DFLT,
  parameter int DAT_W      = 128
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [ENGS_N-1:0]            i_req_vld,
  input  opcode_t [ENGS_N-1:0]         i_req_opcode,
  input  logic [ENGS_N-1:0][DAT_W-1:0] i_req_dat,
  output logic [ENGS_N-1:0]            o_req_rdy,
  input  logic                         i_ptr_avail,
  input  logic                         i_cmpl_vld,
  input  engid_t                       i_cmpl_engid,
  output logic                         o_lk_vld_r,
  output engid_t                       o_lk_engid_r,
  output opcode_t                      o_lk_opcode_r,
  output logic                         o_lk_dat_vld_r,
  output logic [DAT_W-1:0]             o_lk_dat_r,
  output logic                         o_busy
);

  localparam int CW = cred_w(INFLIGHT_N);
  localparam logic [CW-1:0] CRED_MAX = CW'(INFLIGHT_N);

  logic [ENGS_N-1:0] busy_r;
  logic [ENGS_N-1:0] elig;
  logic [ENGS_N-1:0] gnt;
  logic [ENGS_N-1:0] cmpl_clr;
  logic [CW-1:0]     cred_r;
  engid_t            gidx;
  logic              any_gnt;
  logic              cmpl_ok;
  logic              is_push;

  // Eligibility uses registered busy_r only, so rdy never feeds back.
  always_comb begin
    elig = '0;
    for (int e = 0; e < ENGS_N; e++) begin
      elig[e] = i_req_vld[e] & ~busy_r[e] & (cred_r != '0)
              & ((i_req_opcode[e] != OPCODE_PUSH) | i_ptr_avail);
    end
  end

  always_comb begin
    cmpl_ok  = i_cmpl_vld & busy_r[i_cmpl_engid] & (cred_r != CRED_MAX);
    cmpl_clr = '0;
    if (cmpl_ok) cmpl_clr[i_cmpl_engid] = 1'b1;
  end

  stk_rr_arb #(
    .ENGS_N (ENGS_N)
  ) u_arb (
    .clk     (clk),
    .arst    (arst),
    .req     (elig),
    .upd     (any_gnt),
    .gnt     (gnt),
    .gnt_idx (gidx)
  );

  assign any_gnt   = |gnt;
  assign o_req_rdy = gnt;
  assign o_busy    = (cred_r != CRED_MAX);
  assign is_push   = (i_req_opcode[gidx] == OPCODE_PUSH);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      busy_r         <= '0;
      cred_r         <= CRED_MAX;
      o_lk_vld_r     <= 1'b0;
      o_lk_engid_r   <= '0;
      o_lk_opcode_r  <= OPCODE_NOP;
      o_lk_dat_vld_r <= 1'b0;
      o_lk_dat_r     <= '0;
    end else begin
      busy_r <= (busy_r & ~cmpl_clr) | gnt;
      unique case ({any_gnt, cmpl_ok})
        2'b10:   cred_r <= cred_r - CW'(1);
        2'b01:   cred_r <= cred_r + CW'(1);
        default: cred_r <= cred_r;
      endcase
      o_lk_vld_r <= any_gnt;
      if (any_gnt) begin
        o_lk_engid_r   <= gidx;
        o_lk_opcode_r  <= i_req_opcode[gidx];
        o_lk_dat_vld_r <= is_push;
        o_lk_dat_r     <= is_push ? i_req_dat[gidx] : '0;
      end else begin
        o_lk_opcode_r  <= OPCODE_NOP;
        o_lk_dat_vld_r <= 1'b0;
        o_lk_dat_r     <= '0;
      end
    end
  end

`ifndef SYNTHESIS
  logic [ENGS_N-1:0]            pend_r;
  opcode_t [ENGS_N-1:0]         op_q;
  logic [ENGS_N-1:0][DAT_W-1:0] dat_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) pend_r <= '0;
    else      pend_r <= i_req_vld & ~gnt;
  end

  always_ff @(posedge clk) begin
    op_q  <= i_req_opcode;
    dat_q <= i_req_dat;
    if (!arst) begin
      assert (!i_cmpl_vld || cmpl_ok)
        else $error("stk_issue_arb: illegal completion");
      for (int e = 0; e < ENGS_N; e++) begin
        assert (!(i_req_vld[e] && i_req_opcode[e] == OPCODE_NOP))
          else $error("stk_issue_arb: NOP request");
        assert (!pend_r[e] || (i_req_vld[e]
                && i_req_opcode[e] == op_q[e]
                && i_req_dat[e] == dat_q[e]))
          else $error("stk_issue_arb: request changed before accept");
      end
    end
  end
`endif

endmodule
